// File: rtl/timer_array_pkg.sv
// Shared definitions for the multi-channel timer: register offsets, CTRL layout,
// mode encodings and the per-channel FSM state type.
package timer_array_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;
    localparam int CTRL_IM   = 2;
    localparam int CTRL_PS   = 3;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

endpackage

// File: rtl/timer_array_ch.sv
// One timer channel: CTRL/PRESET/COUNT/PEND registers, prescaler and sequencing FSM.
// state | meaning:  IDLE wait for EN | LOAD COUNT<=PRESET | CNT count ticks | INT set PEND
module timer_array_ch
    import timer_array_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int PS_BITS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [31:0]                din,
    input  logic                       we_ctrl,
    input  logic                       we_preset,
    input  logic                       we_status,
    output logic [CTRL_PS+PS_BITS-1:0] ctrl,
    output logic [WIDTH-1:0]           preset,
    output logic [WIDTH-1:0]           count,
    output logic                       pend
);

    localparam int CTRL_W = CTRL_PS + PS_BITS;
    localparam int PS_W   = (1 << PS_BITS) - 1;

    state_t          state;
    logic [PS_W-1:0] ps;
    logic [PS_W-1:0] ps_mask;
    logic            tick;
    logic            en_now;
    logic            unused_din;

    assign ps_mask    = ~({PS_W{1'b1}} << ctrl[CTRL_W-1:CTRL_PS]);
    assign tick       = (ps >= ps_mask);
    // IDLE reacts to an EN write on the same edge so LOAD follows the write immediately
    assign en_now     = we_ctrl ? din[CTRL_EN] : ctrl[CTRL_EN];
    assign unused_din = ^din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            ctrl   <= '0;
            preset <= '0;
            count  <= '0;
            pend   <= 1'b0;
            ps     <= '0;
        end else begin
            case (state)
                ST_IDLE: if (en_now) state <= ST_LOAD;
                ST_LOAD: begin
                    count <= preset;
                    ps    <= '0;
                    state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!ctrl[CTRL_EN]) begin
                        state <= ST_IDLE;
                    end else if (tick) begin
                        ps <= '0;
                        if (count <= WIDTH'(1)) begin
                            count <= '0;
                            state <= ST_INT;
                        end else begin
                            count <= count - 1'b1;
                        end
                    end else begin
                        ps <= ps + 1'b1;
                    end
                end
                ST_INT: begin
                    if (ctrl[CTRL_MODE] == MODE_RELOAD) begin
                        state <= ST_LOAD;
                    end else begin
                        ctrl[CTRL_EN] <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // a bus write to CTRL overrides the one-shot EN clear
            if (we_ctrl)   ctrl   <= din[CTRL_W-1:0];
            if (we_preset) preset <= din[WIDTH-1:0];

            if (state == ST_INT)          pend <= 1'b1;
            else if (we_status && din[0]) pend <= 1'b0;
        end
    end

endmodule

// File: rtl/timer_array.sv
// Multi-channel timer slave: address decode, per-channel instances, read mux and
// the IRQ OR of unmasked pending bits.
module timer_array
    import timer_array_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int WIDTH   = 32,
    parameter int PS_BITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    logic [1:0]  ch_sel;
    logic [1:0]  reg_sel;
    logic [31:0] rd [4];
    logic [3:0]  irq_v;
    logic        unused_addr;

    assign ch_sel      = Addr[5:4];
    assign reg_sel     = Addr[3:2];
    assign unused_addr = ^Addr[31:6];

    for (genvar i = 0; i < 4; i++) begin : g_ch
        if (i < NUM_CH) begin : g_on
            logic [CTRL_PS+PS_BITS-1:0] ctrl;
            logic [WIDTH-1:0]           preset;
            logic [WIDTH-1:0]           count;
            logic                       pend;
            logic                       wr;

            assign wr = WE && (ch_sel == 2'(i));

            timer_array_ch #(
                .WIDTH  (WIDTH),
                .PS_BITS(PS_BITS)
            ) u_ch (
                .clk      (clk),
                .rst_n    (rst_n),
                .din      (Din),
                .we_ctrl  (wr && (reg_sel == REG_CTRL)),
                .we_preset(wr && (reg_sel == REG_PRESET)),
                .we_status(wr && (reg_sel == REG_STATUS)),
                .ctrl     (ctrl),
                .preset   (preset),
                .count    (count),
                .pend     (pend)
            );

            assign rd[i] = (reg_sel == REG_CTRL)   ? 32'(ctrl)   :
                           (reg_sel == REG_PRESET) ? 32'(preset) :
                           (reg_sel == REG_COUNT)  ? 32'(count)  : {31'b0, pend};
            assign irq_v[i] = pend & ctrl[CTRL_IM];
        end else begin : g_off
            assign rd[i]    = '0;
            assign irq_v[i] = 1'b0;
        end
    end

    assign Dout = rd[ch_sel];
    assign IRQ  = |irq_v;

endmodule

// File: tb/tb_timer_array.sv
// Scoreboard bench for timer_array: the driver pushes expected Dout/IRQ per cycle,
// a negedge monitor pops and compares. Expectations come from closed-form timing.
module tb_timer_array;
    import timer_array_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:2] Addr = '0;
    logic        WE = 1'b0;
    logic [31:0] Din = '0;
    logic [31:0] Dout;
    logic        IRQ;

    timer_array #(.NUM_CH(2), .WIDTH(32), .PS_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .Addr(Addr), .WE(WE), .Din(Din), .Dout(Dout), .IRQ(IRQ)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] dout;
        logic        irq;
        bit          chk;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   pend_m[2];
    bit   im_m[2];

    function automatic logic exp_irq();
        return (pend_m[0] & im_m[0]) | (pend_m[1] & im_m[1]);
    endfunction

    // count after edge k of a run whose EN write is edge 0; l is the full period
    function automatic int exp_count(int p, int t, int l, int mode, int k);
        int j;
        if (mode == 0 && k >= l - 1) return 0;
        j = (mode != 0) ? (k % l) : k;
        if (j == 0 || j == l - 1) return 0;
        return p - (j - 1) / t;
    endfunction

    function automatic bit pend_ev(int k, int l, int mode);
        if (k < l) return 1'b0;
        return (mode != 0) ? (k % l == 0) : (k == l);
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk) begin
                    n_tests++;
                    if (Dout !== e.dout) begin
                        n_fail++;
                        $display("FAIL %s: Dout=%h expected %h", e.name, Dout, e.dout);
                    end
                end
                n_tests++;
                if (IRQ !== e.irq) begin
                    n_fail++;
                    $display("FAIL %s irq: IRQ=%b expected %b", e.name, IRQ, e.irq);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic step();
        WE = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string nm, input int ch, input logic [1:0] rg,
                        input logic [31:0] v, input bit chk);
        exp_t e;
        Addr   = 30'({ch[1:0], rg});
        WE     = 1'b0;
        e.name = nm;
        e.dout = v;
        e.irq  = exp_irq();
        e.chk  = chk;
        sb.push_back(e);
    endtask

    task automatic obs(input string nm, input int ch, input logic [1:0] rg, input logic [31:0] v);
        push(nm, ch, rg, v, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input int ch, input logic [1:0] rg, input logic [31:0] d);
        Addr = 30'({ch[1:0], rg});
        Din  = d;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE = 1'b0;
    endtask

    // start a channel, observe n cycles (W1C sampled at edges wa/wb), end with register reads
    task automatic run_ch(input int ch, input int p, input int s, input int mode, input int im,
                          input int n, input int wa, input int wb);
        int t, l, en;
        bit w_now, w_next;
        t = 1 << s;
        l = ((p > 1) ? p : 1) * t + 2;
        bus_write(ch, REG_PRESET, 32'(p));
        bus_write(ch, REG_CTRL, 32'((s << 3) | (im << 2) | (mode << 1) | 1));
        im_m[ch] = (im != 0);
        w_now = 1'b0;
        for (int k = 0; k <= n; k++) begin
            if (k >= 1 && pend_ev(k, l, mode)) pend_m[ch] = 1'b1;
            else if (w_now)                    pend_m[ch] = 1'b0;
            w_next = (k + 1 == wa) || (k + 1 == wb);
            if (w_next) begin
                Addr = 30'({ch[1:0], REG_STATUS});
                Din  = 32'd1;
                WE   = 1'b1;
            end else if (k == n - 2) begin
                en = (mode == 0 && k >= l) ? 0 : 1;
                push("ctrl", ch, REG_CTRL, 32'((s << 3) | (im << 2) | (mode << 1) | en), 1'b1);
            end else if (k == n - 1) begin
                push("preset", ch, REG_PRESET, 32'(p), 1'b1);
            end else if (k == n) begin
                push("status", ch, REG_STATUS, 32'(pend_m[ch]), 1'b1);
            end else begin
                push("count", ch, REG_COUNT, 32'(exp_count(p, t, l, mode, k)), k >= 1);
            end
            w_now = w_next;
            @(posedge clk);
            #1;
        end
        WE = 1'b0;
    endtask

    task automatic cleanup(input int ch);
        bus_write(ch, REG_CTRL, 32'd0);
        im_m[ch] = 1'b0;
        repeat (4) step();
        bus_write(ch, REG_STATUS, 32'd1);
        pend_m[ch] = 1'b0;
        step();
    endtask

    initial begin : driver
        int ch, p, s, mode, im, l, n, wa;
        pend_m = '{0, 0};
        im_m   = '{0, 0};
        #1;
        obs("rst_ctrl", 0, REG_CTRL, 32'd0);
        obs("rst_count", 1, REG_COUNT, 32'd0);
        rst_n = 1'b1;

        // asynchronous reset in the middle of a count
        bus_write(0, REG_PRESET, 32'd10);
        bus_write(0, REG_CTRL, 32'd1);
        repeat (8) step();
        obs("mid_count", 0, REG_COUNT, 32'd3);
        rst_n = 1'b0;
        #1;
        obs("rst_async_count", 0, REG_COUNT, 32'd0);
        obs("rst_async_ctrl", 0, REG_CTRL, 32'd0);
        obs("rst_async_preset", 0, REG_PRESET, 32'd0);
        rst_n = 1'b1;
        bus_write(0, REG_PRESET, 32'd7);
        for (int i = 0; i < 10; i++) obs("post_rst_idle", 0, REG_COUNT, 32'd0);

        // decode: absent channel and read-only COUNT
        bus_write(3, REG_CTRL, 32'h1F);
        bus_write(3, REG_PRESET, 32'hAB);
        bus_write(0, REG_PRESET, 32'd9);
        bus_write(0, REG_CTRL, 32'h31);
        bus_write(0, REG_COUNT, 32'h55);
        obs("count_ro", 0, REG_COUNT, 32'd9);
        obs("ch3_ctrl", 3, REG_CTRL, 32'd0);
        obs("ch3_preset", 3, REG_PRESET, 32'd0);
        obs("ch3_count", 3, REG_COUNT, 32'd0);
        obs("ch3_status", 3, REG_STATUS, 32'd0);
        obs("count_held", 0, REG_COUNT, 32'd9);
        cleanup(0);

        run_ch(0, 5, 0, 0, 1, 10, -1, -1);
        cleanup(0);
        run_ch(1, 3, 0, 1, 1, 24, 7, 15);
        cleanup(1);
        run_ch(0, 2, 2, 0, 1, 14, -1, -1);
        cleanup(0);
        run_ch(0, 1, 0, 0, 0, 8, -1, -1);
        cleanup(0);

        for (int it = 0; it < 12; it++) begin
            ch   = $urandom_range(0, 1);
            p    = $urandom_range(0, 6);
            s    = $urandom_range(0, 2);
            mode = $urandom_range(0, 1);
            im   = $urandom_range(0, 1);
            l    = ((p > 1) ? p : 1) * (1 << s) + 2;
            n    = 2 * l + 4;
            wa   = $urandom_range(1, n - 4);
            run_ch(ch, p, s, mode, im, n, wa, -1);
            cleanup(ch);
        end

        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
